pqsdn_cam_learn_ctrl: RTL and testbench
=======================================

// Module: pqsdn_cam_learn_ctrl
// PURPOSE
//  Table manager upstream of pqsdn_cam_new; it is the only writer of the CAM.
//  Accepts insert/delete key requests, checks for duplicates through the CAM search port and allocates free slots.
//  Issues CAM writes and returns a status/address response.
//  Deleted/unused slots hold NULL_KEY; an internal valid bitmap qualifies every CAM hit.
// PARAMETERS
//  DATA_W    64         key width, equal to the CAM DATA_W
//  ADDR_W    6          CAM address width; NUM_ENT = 2**ADDR_W
//  NULL_KEY  {DATA_W{1}} key value reserved to mark empty slots
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       reset: synchronous, active-low
//  req_valid_i     in   1       request valid
//  req_ready_o     out  1       request ready; high only in IDLE
//  req_op_i        in   1       0 = insert, 1 = delete
//  req_key_i       in   DATA_W  request key
//  rsp_valid_o     out  1       response valid
//  rsp_ready_i     in   1       response accept
//  rsp_status_o    out  3       0 ADDED, 1 DELETED, 2 EXISTS, 3 FULL, 4 NOT_FOUND, 5 BAD_KEY
//  rsp_addr_o      out  ADDR_W  slot written/found; 0 for FULL, NOT_FOUND, BAD_KEY
//  cam_wr_en_o     out  1       to CAM en_a_i
//  cam_wr_addr_o   out  ADDR_W  to CAM wraddr_a_i
//  cam_wr_data_o   out  DATA_W  to CAM wrdata_a_i
//  cam_srch_en_o   out  1       to CAM rden_b_i
//  cam_srch_key_o  out  DATA_W  to CAM rddata_b_i
//  cam_srch_addr_i in   ADDR_W  from CAM rdaddr_b_o
//  cam_srch_hit_i  in   1       from CAM rdvalid_b_o
//  used_cnt_o      out  ADDR_W+1 number of valid entries
// BEHAVIOUR
//  Reset values: all outputs 0 except req_ready_o = 1. FSM = IDLE, bitmap = 0, key register = 0.
//  Reset mid-operation aborts any response or write. CAM contents are not touched; stale entries are masked by the cleared bitmap.
//  FSM: IDLE -> SRCH -> {WRITE -> SETTLE ->} RSP -> IDLE.
//  IDLE: on req_valid_i & req_ready_o (cycle 0), register op and key.
//  SRCH (cycle 1):
//   - Drive cam_srch_en_o = 1 and cam_srch_key_o = key.
//   - hit = cam_srch_hit_i & bitmap[cam_srch_addr_i]; sample hit and address.
//   - Sample free_addr = lowest index with bitmap bit 0.
//  Decision in SRCH, evaluated in order:
//   - key == NULL_KEY -> BAD_KEY
//   - insert & hit -> EXISTS, addr = hit address
//   - insert & no free slot -> FULL
//   - delete & !hit -> NOT_FOUND
//   - otherwise -> WRITE
//  Any non-WRITE decision goes straight to RSP, so rsp_valid_o is first high in cycle 2.
//  WRITE (cycle 2): one-cycle pulse cam_wr_en_o = 1.
//   - insert: wr_addr = free_addr, wr_data = key; set bitmap bit.
//   - delete: wr_addr = hit address, wr_data = NULL_KEY; clear bitmap bit.
//  SETTLE (cycle 3): idle cycle covering the CAM's one-cycle registered write, so the next search sees it.
//  RSP: rsp_valid_o is high from cycle 4 (write path) or cycle 2 (no write).
//   - rsp_valid_o, status and addr hold until rsp_ready_i.
//   - Return to IDLE on the accepting edge; the next request can be accepted one cycle later.
//  Exactly one request is in flight; no new search is issued before SETTLE completes.
//  used_cnt_o is updated in WRITE: +1 on insert, -1 on delete; range 0..NUM_ENT.
//  cam_srch_en_o and cam_wr_en_o are never asserted in the same cycle.
// CONFIGURATION
//  PQSDN_CAM_LEARN_STATS_EN defined: adds outputs stat_add_o, stat_del_o and stat_drop_o (32 b each).
//   - Counters increment on RSP acceptance: ADDED, DELETED, and FULL|EXISTS|NOT_FOUND|BAD_KEY respectively.
//   - Counters saturate at 2**32-1 and clear on reset.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package pqsdn_cam_pkg holds:
//   - status codes (localparams ST_ADDED .. ST_BAD_KEY)
//   - FSM state encodings
//   - op encodings OP_INS/OP_DEL
//  Sub-module pqsdn_cam_free_enc: combinational lowest-zero priority encoder over the bitmap.
//   - Outputs free_addr and any_free.
//   - Parameterised by ADDR_W.
// TESTING (bench instantiates pqsdn_cam_new as the CAM model)
//  After reset, insert key 0x11:
//   - cam_wr_en_o pulses in cycle 2 with addr 0 and data 0x11.
//   - rsp ADDED addr 0 in cycle 4; used_cnt_o = 1.
//  Insert 0x11 again -> EXISTS addr 0 in cycle 2; no write pulse; used_cnt_o stays 1.
//  Fill all 64 slots, then insert 0x99 -> FULL addr 0.
//   - Delete the key in slot 5 -> DELETED addr 5, wr_data = NULL_KEY.
//   - Re-insert 0x99 -> ADDED addr 5.
//  Delete 0x77, never inserted -> NOT_FOUND; insert NULL_KEY -> BAD_KEY; no CAM writes for either.
//  Hold rsp_ready_i low for 10 cycles -> rsp_valid_o, status and addr stay stable; req_ready_o stays low.
//  Assert rst_n = 0 during WRITE with 3 entries used:
//   - After reset, used_cnt_o = 0 and rsp_valid_o = 0.
//   - Re-inserting an old key -> ADDED addr 0 (stale hit masked by the bitmap).

Source files
------------

// File: rtl/pqsdn_cam_pkg.sv
// pqsdn_cam_pkg: shared status codes, op encodings and controller state encodings for the CAM learn controller
package pqsdn_cam_pkg;
    localparam logic [2:0] ST_ADDED     = 3'd0;
    localparam logic [2:0] ST_DELETED   = 3'd1;
    localparam logic [2:0] ST_EXISTS    = 3'd2;
    localparam logic [2:0] ST_FULL      = 3'd3;
    localparam logic [2:0] ST_NOT_FOUND = 3'd4;
    localparam logic [2:0] ST_BAD_KEY   = 3'd5;
    localparam logic OP_INS = 1'b0;
    localparam logic OP_DEL = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_SRCH,
        S_WRITE,
        S_SETTLE,
        S_RSP
    } state_t;
endpackage

// File: rtl/pqsdn_cam_learn_ctrl_if.sv
// pqsdn_cam_learn_ctrl_if: request/response channel of the CAM learn controller
//   req_valid_i/req_ready_o/req_op_i/req_key_i : key request (op 0 insert, 1 delete)
//   rsp_valid_o/rsp_ready_i/rsp_status_o/rsp_addr_o : status/address response
//   Signal suffixes are from the controller's point of view (slave modport).
interface pqsdn_cam_learn_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_op_i;
    logic [DATA_W-1:0] req_key_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [2:0]        rsp_status_o;
    logic [ADDR_W-1:0] rsp_addr_o;
    modport master (
        output req_valid_i, req_op_i, req_key_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_status_o, rsp_addr_o
    );
    modport slave (
        input  req_valid_i, req_op_i, req_key_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_status_o, rsp_addr_o
    );
endinterface

// File: rtl/pqsdn_cam_free_enc.sv
// pqsdn_cam_free_enc: lowest-zero priority encoder over the slot valid bitmap
//   i_bitmap    : slot valid bits, 2**ADDR_W wide
//   o_free_addr : lowest index whose bit is 0 (0 when none)
//   o_any_free  : at least one bit is 0
module pqsdn_cam_free_enc #(
    parameter int ADDR_W = 6
) (
    input  logic [(1<<ADDR_W)-1:0] i_bitmap,
    output logic [ADDR_W-1:0]      o_free_addr,
    output logic                   o_any_free
);
    always_comb begin
        o_free_addr = '0;
        o_any_free  = 1'b0;
        // descending scan so the lowest free index is written last and wins
        for (int i = (1 << ADDR_W) - 1; i >= 0; i--) begin
            if (!i_bitmap[i]) begin
                o_free_addr = ADDR_W'(i);
                o_any_free  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pqsdn_cam_learn_ctrl.sv
// pqsdn_cam_learn_ctrl: sole CAM writer; handles insert/delete with duplicate check and free-slot allocation
//   clk, rst_n (sync, active-low)
//   req_if          : request/response channel (slave modport)
//   cam_wr_*        : CAM write port (en/addr/data)
//   cam_srch_*      : CAM search port (en/key out, addr/hit in)
//   used_cnt_o      : number of valid entries
//   Optional macro PQSDN_CAM_LEARN_STATS_EN adds stat_add_o/stat_del_o/stat_drop_o counters.
module pqsdn_cam_learn_ctrl
    import pqsdn_cam_pkg::*;
#(
    parameter int               DATA_W   = 64,
    parameter int               ADDR_W   = 6,
    parameter logic [DATA_W-1:0] NULL_KEY = {DATA_W{1'b1}}
) (
    input  logic                clk,
    input  logic                rst_n,
    pqsdn_cam_learn_ctrl_if.slave req_if,
    output logic                cam_wr_en_o,
    output logic [ADDR_W-1:0]   cam_wr_addr_o,
    output logic [DATA_W-1:0]   cam_wr_data_o,
    output logic                cam_srch_en_o,
    output logic [DATA_W-1:0]   cam_srch_key_o,
    input  logic [ADDR_W-1:0]   cam_srch_addr_i,
    input  logic                cam_srch_hit_i,
    output logic [ADDR_W:0]     used_cnt_o
`ifdef PQSDN_CAM_LEARN_STATS_EN
    ,
    output logic [31:0]         stat_add_o,
    output logic [31:0]         stat_del_o,
    output logic [31:0]         stat_drop_o
`endif
);
    localparam int NUM_ENT = 1 << ADDR_W;
    state_t              r_state;
    logic                r_op;
    logic [DATA_W-1:0]   r_key;
    logic [NUM_ENT-1:0]  r_bitmap;
    logic [ADDR_W:0]     r_used;
    logic                r_req_ready;
    logic                r_srch_en;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_rsp_valid;
    logic [2:0]          r_status;
    logic [ADDR_W-1:0]   r_rsp_addr;
    logic                w_hit;
    logic                w_any_free;
    logic                w_do_wr;
    logic [ADDR_W-1:0]   w_free_addr;
    logic [ADDR_W-1:0]   w_addr;
    logic [2:0]          w_status;
    logic                w_rsp_acc;

    pqsdn_cam_free_enc #(.ADDR_W(ADDR_W)) u_free_enc (
        .i_bitmap   (r_bitmap),
        .o_free_addr(w_free_addr),
        .o_any_free (w_any_free)
    );

    // CAM may still hold stale keys in freed/reset slots; only bitmap-valid hits count
    assign w_hit     = cam_srch_hit_i & r_bitmap[cam_srch_addr_i];
    assign w_rsp_acc = (r_state == S_RSP) & req_if.rsp_ready_i;

    always_comb begin
        w_status = (r_key == NULL_KEY) ? ST_BAD_KEY :
                   (r_op == OP_INS)    ? (w_hit ? ST_EXISTS : (w_any_free ? ST_ADDED : ST_FULL)) :
                                         (w_hit ? ST_DELETED : ST_NOT_FOUND);
        w_do_wr  = (w_status == ST_ADDED) | (w_status == ST_DELETED);
        w_addr   = (w_status == ST_ADDED)                               ? w_free_addr     :
                   ((w_status == ST_EXISTS) | (w_status == ST_DELETED)) ? cam_srch_addr_i : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_INS;
            r_key       <= '0;
            r_bitmap    <= '0;
            r_used      <= '0;
            r_req_ready <= 1'b1;
            r_srch_en   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_status    <= '0;
            r_rsp_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_if.req_valid_i) begin
                        r_op        <= req_if.req_op_i;
                        r_key       <= req_if.req_key_i;
                        r_req_ready <= 1'b0;
                        r_srch_en   <= 1'b1;
                        r_state     <= S_SRCH;
                    end
                end
                S_SRCH: begin
                    r_srch_en  <= 1'b0;
                    r_status   <= w_status;
                    r_rsp_addr <= w_addr;
                    if (w_do_wr) begin
                        r_wr_en          <= 1'b1;
                        r_wr_addr        <= w_addr;
                        r_wr_data        <= (r_op == OP_INS) ? r_key : NULL_KEY;
                        r_bitmap[w_addr] <= (r_op == OP_INS);
                        r_used           <= (r_op == OP_INS) ? r_used + 1'b1 : r_used - 1'b1;
                        r_state          <= S_WRITE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    if (req_if.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_if.req_ready_o  = r_req_ready;
    assign req_if.rsp_valid_o  = r_rsp_valid;
    assign req_if.rsp_status_o = r_status;
    assign req_if.rsp_addr_o   = r_rsp_addr;
    assign cam_wr_en_o         = r_wr_en;
    assign cam_wr_addr_o       = r_wr_addr;
    assign cam_wr_data_o       = r_wr_data;
    assign cam_srch_en_o       = r_srch_en;
    assign cam_srch_key_o      = r_key;
    assign used_cnt_o          = r_used;

`ifdef PQSDN_CAM_LEARN_STATS_EN
    logic [31:0] r_stat_add;
    logic [31:0] r_stat_del;
    logic [31:0] r_stat_drop;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_add  <= '0;
            r_stat_del  <= '0;
            r_stat_drop <= '0;
        end else if (w_rsp_acc) begin
            if (r_status == ST_ADDED) begin
                if (r_stat_add != '1) r_stat_add <= r_stat_add + 1'b1;
            end else if (r_status == ST_DELETED) begin
                if (r_stat_del != '1) r_stat_del <= r_stat_del + 1'b1;
            end else begin
                if (r_stat_drop != '1) r_stat_drop <= r_stat_drop + 1'b1;
            end
        end
    end
    assign stat_add_o  = r_stat_add;
    assign stat_del_o  = r_stat_del;
    assign stat_drop_o = r_stat_drop;
`else
    logic w_unused;
    assign w_unused = w_rsp_acc;
`endif
endmodule

// File: tb/tb_pqsdn_cam_learn_ctrl.sv
// tb_pqsdn_cam_learn_ctrl: scoreboard bench for the CAM learn controller with a behavioural CAM
module tb_pqsdn_cam_learn_ctrl;
    import pqsdn_cam_pkg::*;
    localparam logic [63:0] NULL_KEY = '1;

    logic        clk;
    logic        rst_n;
    logic        cam_wr_en;
    logic [5:0]  cam_wr_addr;
    logic [63:0] cam_wr_data;
    logic        cam_srch_en;
    logic [63:0] cam_srch_key;
    logic [5:0]  cam_srch_addr;
    logic        cam_srch_hit;
    logic [6:0]  used_cnt;
    logic [63:0] cam_mem [64];

    int n_vec = 0;
    int n_err = 0;
    int model_used = 0;
    logic [8:0] exp_q[$];

    pqsdn_cam_learn_ctrl_if #(.DATA_W(64), .ADDR_W(6)) bus ();

    pqsdn_cam_learn_ctrl #(.DATA_W(64), .ADDR_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_if         (bus),
        .cam_wr_en_o    (cam_wr_en),
        .cam_wr_addr_o  (cam_wr_addr),
        .cam_wr_data_o  (cam_wr_data),
        .cam_srch_en_o  (cam_srch_en),
        .cam_srch_key_o (cam_srch_key),
        .cam_srch_addr_i(cam_srch_addr),
        .cam_srch_hit_i (cam_srch_hit),
        .used_cnt_o     (used_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CAM model: registered write, combinational lowest-index match
    initial for (int i = 0; i < 64; i++) cam_mem[i] = NULL_KEY;
    always @(posedge clk) if (cam_wr_en) cam_mem[cam_wr_addr] <= cam_wr_data;
    always_comb begin
        cam_srch_hit  = 1'b0;
        cam_srch_addr = '0;
        for (int i = 63; i >= 0; i--) begin
            if (cam_srch_en && cam_mem[i] == cam_srch_key) begin
                cam_srch_hit  = 1'b1;
                cam_srch_addr = 6'(i);
            end
        end
    end

    // scoreboard monitor: compares every accepted response against the queue head
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got status %0d addr %0d, none expected", bus.rsp_status_o, bus.rsp_addr_o);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({bus.rsp_status_o, bus.rsp_addr_o} !== e) begin
                    n_err++;
                    $display("FAIL rsp: got status %0d addr %0d, expected status %0d addr %0d",
                             bus.rsp_status_o, bus.rsp_addr_o, e[8:6], e[5:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic op, input logic [63:0] key, input logic [2:0] est,
                          input logic [5:0] eaddr, input int hold);
        logic       do_wr;
        logic       both;
        int         cyc;
        int         wr_cyc;
        int         rsp_cyc;
        logic [5:0] wa;
        logic [63:0] wd;
        do_wr  = (est == ST_ADDED) || (est == ST_DELETED);
        both   = 1'b0;
        wr_cyc = 0;
        wa     = '0;
        wd     = '0;
        for (int k = 0; k < 20 && !bus.req_ready_o; k++) tick();
        check("req_ready_before", 64'(bus.req_ready_o), 64'd1);
        bus.rsp_ready_i = (hold == 0);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_key_i   = key;
        exp_q.push_back({est, eaddr});
        tick();
        bus.req_valid_i = 1'b0;
        cyc = 1;
        check("srch_key", cam_srch_key, key);
        check("srch_en", 64'(cam_srch_en), 64'd1);
        while (cyc < 20 && !bus.rsp_valid_o) begin
            if (cam_wr_en && wr_cyc == 0) begin
                wr_cyc = cyc;
                wa     = cam_wr_addr;
                wd     = cam_wr_data;
            end
            if (cam_wr_en && cam_srch_en) both = 1'b1;
            tick();
            cyc++;
        end
        rsp_cyc = bus.rsp_valid_o ? cyc : 0;
        check("rsp_cycle", 64'(rsp_cyc), do_wr ? 64'd4 : 64'd2);
        check("wr_cycle", 64'(wr_cyc), do_wr ? 64'd2 : 64'd0);
        check("wr_srch_overlap", 64'(both), 64'd0);
        if (do_wr) begin
            check("wr_addr", 64'(wa), 64'(eaddr));
            check("wr_data", wd, (op == OP_INS) ? key : NULL_KEY);
        end
        if (est == ST_ADDED) model_used++;
        if (est == ST_DELETED) model_used--;
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(bus.rsp_valid_o), 64'd1);
            check("hold_status", 64'(bus.rsp_status_o), 64'(est));
            check("hold_addr", 64'(bus.rsp_addr_o), 64'(eaddr));
            check("hold_req_ready", 64'(bus.req_ready_o), 64'd0);
            tick();
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        check("used_cnt", 64'(used_cnt), 64'(model_used));
        check("req_ready_after", 64'(bus.req_ready_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = OP_INS;
        bus.req_key_i   = '0;
        bus.rsp_ready_i = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_wr_en", 64'(cam_wr_en), 64'd0);
        check("rst_srch_en", 64'(cam_srch_en), 64'd0);
        check("rst_used", 64'(used_cnt), 64'd0);
        check("rst_srch_key", cam_srch_key, 64'd0);
        rst_n = 1'b1;
        tick();
        do_req(OP_INS, 64'h11, ST_ADDED, 6'd0, 0);
        do_req(OP_INS, 64'h11, ST_EXISTS, 6'd0, 0);
        for (int i = 1; i < 64; i++) do_req(OP_INS, 64'h100 + 64'(i), ST_ADDED, 6'(i), 0);
        do_req(OP_INS, 64'h99, ST_FULL, 6'd0, 0);
        do_req(OP_DEL, 64'h105, ST_DELETED, 6'd5, 0);
        do_req(OP_INS, 64'h99, ST_ADDED, 6'd5, 0);
        do_req(OP_DEL, 64'h77, ST_NOT_FOUND, 6'd0, 0);
        do_req(OP_INS, NULL_KEY, ST_BAD_KEY, 6'd0, 0);
        do_req(OP_DEL, NULL_KEY, ST_BAD_KEY, 6'd0, 0);
        do_req(OP_DEL, 64'h99, ST_DELETED, 6'd5, 0);
        do_req(OP_INS, 64'h11, ST_EXISTS, 6'd0, 10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_used = 0;
        tick();
        do_req(OP_INS, 64'hA1, ST_ADDED, 6'd0, 0);
        do_req(OP_INS, 64'hA2, ST_ADDED, 6'd1, 0);
        do_req(OP_INS, 64'hA3, ST_ADDED, 6'd2, 0);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = OP_INS;
        bus.req_key_i   = 64'hA4;
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        check("abort_in_write", 64'(cam_wr_en), 64'd1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_used = 0;
        check("abort_used", 64'(used_cnt), 64'd0);
        check("abort_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("abort_req_ready", 64'(bus.req_ready_o), 64'd1);
        tick();
        do_req(OP_INS, 64'hA1, ST_ADDED, 6'd0, 0);
        do_req(OP_INS, 64'hA2, ST_ADDED, 6'd1, 0);
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
